// File: rtl/hit_judge.sv
//============================================================================
// Module   : hit_judge
// Brief    : Per-frame bullet/tank hit detection, scoring and round control.
//            Detects bullet-to-opposing-tank overlap, scores the hit, pulses
//            GReset for one frame, holds play with Flash high, and ends the
//            match at WIN_SCORE. RESTART_KEY restarts a finished match.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module hit_judge #(
    parameter int         TANK_HALF   = 8,
    parameter int         HOLD_FRAMES = 60,
    parameter int         WIN_SCORE   = 9,
    parameter logic [7:0] RESTART_KEY = 8'h28
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic [9:0] Bullet0X,
    input  logic [9:0] Bullet0Y,
    input  logic [9:0] Bullet1X,
    input  logic [9:0] Bullet1Y,
    input  logic [9:0] BulletSize,
    input  logic [9:0] Tank0X,
    input  logic [9:0] Tank0Y,
    input  logic [9:0] Tank1X,
    input  logic [9:0] Tank1Y,
    output logic       GReset,
    output logic [3:0] Score0,
    output logic [3:0] Score1,
    output logic       Flash,
    output logic [1:0] Winner
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [10:0] c_HALF      = 11'(TANK_HALF);
    localparam logic [3:0]  c_WIN       = 4'(WIN_SCORE);
    localparam logic [7:0]  c_HOLD_LOAD = 8'(HOLD_FRAMES - 1);

    // Registered state and outputs
    state_t     r_state;
    logic [7:0] r_hold;
    logic [3:0] r_score0;
    logic [3:0] r_score1;
    logic       r_greset;
    logic       r_flash;
    logic [1:0] r_winner;

    // Next-state values
    state_t     w_state_nxt;
    logic [7:0] w_hold_nxt;
    logic [3:0] w_score0_nxt;
    logic [3:0] w_score1_nxt;
    logic       w_greset_nxt;
    logic       w_flash_nxt;
    logic [1:0] w_winner_nxt;

    logic [10:0] w_bound;
    logic        w_act0;
    logic        w_act1;
    logic        w_hit0;
    logic        w_hit1;

    // Inclusive box overlap; differences are taken modulo 2^11 and treated
    // as two's complement, which covers the full +/-1023 range of 10-bit
    // coordinates.
    function automatic logic f_overlap(
        input logic [9:0]  bx,
        input logic [9:0]  by,
        input logic [9:0]  tx,
        input logic [9:0]  ty,
        input logic [10:0] bound
    );
        logic [10:0] dx;
        logic [10:0] dy;
        logic [10:0] ax;
        logic [10:0] ay;
        dx = {1'b0, bx} - {1'b0, tx};
        dy = {1'b0, by} - {1'b0, ty};
        ax = dx[10] ? (~dx + 11'd1) : dx;
        ay = dy[10] ? (~dy + 11'd1) : dy;
        return (ax <= bound) && (ay <= bound);
    endfunction

    // Overlap bound, bullet activity and cross-tank hit detection
    always_comb begin
        w_bound = {1'b0, BulletSize} + c_HALF;
        w_act0  = (Bullet0X != 10'd0) || (Bullet0Y != 10'd0);
        w_act1  = (Bullet1X != 10'd0) || (Bullet1Y != 10'd0);
        w_hit0  = w_act0 && f_overlap(Bullet0X, Bullet0Y, Tank1X, Tank1Y, w_bound);
        w_hit1  = w_act1 && f_overlap(Bullet1X, Bullet1Y, Tank0X, Tank0Y, w_bound);
    end

    // Round control: next state, scores, hold counter and output values
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_score0_nxt = r_score0;
        w_score1_nxt = r_score1;
        w_greset_nxt = 1'b0;
        w_winner_nxt = r_winner;
        case (r_state)
            ST_PLAY: begin
                if (w_hit0 || w_hit1) begin
                    if (w_hit0 && (r_score0 < c_WIN)) begin
                        w_score0_nxt = r_score0 + 4'd1;
                    end
                    if (w_hit1 && (r_score1 < c_WIN)) begin
                        w_score1_nxt = r_score1 + 4'd1;
                    end
                    w_greset_nxt = 1'b1;
                    w_hold_nxt   = c_HOLD_LOAD;
                    w_state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold == 8'd0) begin
                    if ((r_score0 == c_WIN) || (r_score1 == c_WIN)) begin
                        w_winner_nxt = {(r_score1 == c_WIN), (r_score0 == c_WIN)};
                        w_state_nxt  = ST_OVER;
                    end else begin
                        w_state_nxt = ST_PLAY;
                    end
                end else begin
                    w_hold_nxt = r_hold - 8'd1;
                end
            end
            ST_OVER: begin
                if (keycode == RESTART_KEY) begin
                    w_score0_nxt = 4'd0;
                    w_score1_nxt = 4'd0;
                    w_winner_nxt = 2'b00;
                    w_greset_nxt = 1'b1;
                    w_state_nxt  = ST_PLAY;
                end
            end
            default: begin
                w_state_nxt = ST_PLAY;
            end
        endcase
        w_flash_nxt = (w_state_nxt == ST_HOLD);
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_PLAY;
            r_hold   <= 8'd0;
            r_score0 <= 4'd0;
            r_score1 <= 4'd0;
            r_greset <= 1'b0;
            r_flash  <= 1'b0;
            r_winner <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_score0 <= w_score0_nxt;
            r_score1 <= w_score1_nxt;
            r_greset <= w_greset_nxt;
            r_flash  <= w_flash_nxt;
            r_winner <= w_winner_nxt;
        end
    end

    assign GReset = r_greset;
    assign Score0 = r_score0;
    assign Score1 = r_score1;
    assign Flash  = r_flash;
    assign Winner = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_hit_judge.sv
//============================================================================
// Module   : tb_hit_judge
// Brief    : Directed self-checking bench for hit_judge.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_hit_judge;

    localparam int HOLD = 60;

    logic       frame_clk;
    logic       Reset_n;
    logic [7:0] keycode;
    logic [9:0] Bullet0X, Bullet0Y, Bullet1X, Bullet1Y, BulletSize;
    logic [9:0] Tank0X, Tank0Y, Tank1X, Tank1Y;
    logic       GReset;
    logic [3:0] Score0, Score1;
    logic       Flash;
    logic [1:0] Winner;

    int n_checks = 0;
    int n_fail   = 0;

    hit_judge #(
        .TANK_HALF   (8),
        .HOLD_FRAMES (HOLD),
        .WIN_SCORE   (9),
        .RESTART_KEY (8'h28)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .Bullet0X   (Bullet0X),
        .Bullet0Y   (Bullet0Y),
        .Bullet1X   (Bullet1X),
        .Bullet1Y   (Bullet1Y),
        .BulletSize (BulletSize),
        .Tank0X     (Tank0X),
        .Tank0Y     (Tank0Y),
        .Tank1X     (Tank1X),
        .Tank1Y     (Tank1Y),
        .GReset     (GReset),
        .Score0     (Score0),
        .Score1     (Score1),
        .Flash      (Flash),
        .Winner     (Winner)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic park();
        Bullet0X = 10'd0; Bullet0Y = 10'd0;
        Bullet1X = 10'd0; Bullet1Y = 10'd0;
    endtask

    // Apply a hit, check the scoring edge, then wait out the hold
    task automatic hit_hold(input logic [9:0] b0x, input logic [9:0] b0y,
                            input logic [9:0] b1x, input logic [9:0] b1y,
                            input logic [3:0] e0, input logic [3:0] e1,
                            input string tag);
        Bullet0X = b0x; Bullet0Y = b0y; Bullet1X = b1x; Bullet1Y = b1y;
        step();
        chk({tag, "_s0"}, 32'(Score0), 32'(e0));
        chk({tag, "_s1"}, 32'(Score1), 32'(e1));
        chk({tag, "_gr"}, 32'(GReset), 32'd1);
        park();
        repeat (HOLD) step();
        chk({tag, "_flash_end"}, 32'(Flash), 32'd0);
    endtask

    // Apply a near-miss and confirm nothing scores
    task automatic miss(input logic [9:0] b0x, input logic [9:0] b0y,
                        input logic [3:0] e0, input string tag);
        Bullet0X = b0x; Bullet0Y = b0y;
        step();
        chk({tag, "_s0"}, 32'(Score0), 32'(e0));
        chk({tag, "_gr"}, 32'(GReset), 32'd0);
        park();
    endtask

    initial begin
        int flash_cnt;
        int gr_cnt;
        Reset_n    = 1'b0;
        keycode    = 8'h00;
        BulletSize = 10'd4;
        Tank0X = 10'd100; Tank0Y = 10'd400;
        Tank1X = 10'd300; Tank1Y = 10'd200;
        park();

        // Reset state
        #12;
        chk("rst_gr", 32'(GReset), 32'd0);
        chk("rst_s0", 32'(Score0), 32'd0);
        chk("rst_s1", 32'(Score1), 32'd0);
        chk("rst_flash", 32'(Flash), 32'd0);
        chk("rst_win", 32'(Winner), 32'd0);
        #1 Reset_n = 1'b1;
        step();
        chk("idle_s0", 32'(Score0), 32'd0);

        // Basic hit with pulse width and hold length measurement
        Bullet0X = 10'd305; Bullet0Y = 10'd204;
        step();
        chk("basic_s0", 32'(Score0), 32'd1);
        chk("basic_gr", 32'(GReset), 32'd1);
        chk("basic_flash", 32'(Flash), 32'd1);
        park();
        flash_cnt = 1;
        gr_cnt    = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (GReset) gr_cnt++;
            if (Flash) flash_cnt++;
            else break;
        end
        chk("basic_gr_width", 32'(gr_cnt), 32'd1);
        chk("basic_flash_len", 32'(flash_cnt), 32'(HOLD));
        step();
        chk("basic_play_s0", 32'(Score0), 32'd1);

        // Inclusive boundaries on both axes and both sides
        hit_hold(10'd312, 10'd200, 10'd0, 10'd0, 4'd2, 4'd0, "xp12");
        miss(10'd313, 10'd200, 4'd2, "xp13");
        hit_hold(10'd288, 10'd200, 10'd0, 10'd0, 4'd3, 4'd0, "xn12");
        miss(10'd287, 10'd200, 4'd3, "xn13");
        hit_hold(10'd300, 10'd212, 10'd0, 10'd0, 4'd4, 4'd0, "yp12");
        miss(10'd300, 10'd213, 4'd4, "yp13");
        hit_hold(10'd300, 10'd188, 10'd0, 10'd0, 4'd5, 4'd0, "yn12");
        miss(10'd300, 10'd187, 4'd5, "yn13");

        // Own-tank and parked-bullet exclusion
        miss(10'd100, 10'd400, 4'd5, "self0");
        Tank0X = 10'd4; Tank0Y = 10'd4;
        step();
        chk("parked_s1", 32'(Score1), 32'd0);
        chk("parked_gr", 32'(GReset), 32'd0);
        Tank0X = 10'd100; Tank0Y = 10'd400;

        // Bullet 1 scores on tank 0
        hit_hold(10'd0, 10'd0, 10'd97, 10'd405, 4'd5, 4'd1, "hit1");

        // Climb to 8/8
        hit_hold(10'd300, 10'd200, 10'd100, 10'd400, 4'd6, 4'd2, "dbl_a");
        hit_hold(10'd300, 10'd200, 10'd100, 10'd400, 4'd7, 4'd3, "dbl_b");
        hit_hold(10'd300, 10'd200, 10'd100, 10'd400, 4'd8, 4'd4, "dbl_c");
        for (int k = 5; k <= 8; k++) begin
            hit_hold(10'd0, 10'd0, 10'd100, 10'd400, 4'd8, 4'(k), "climb1");
        end

        // Simultaneous final hit -> tie
        Bullet0X = 10'd300; Bullet0Y = 10'd200;
        Bullet1X = 10'd100; Bullet1Y = 10'd400;
        step();
        chk("final_s0", 32'(Score0), 32'd9);
        chk("final_s1", 32'(Score1), 32'd9);
        chk("final_gr", 32'(GReset), 32'd1);
        park();
        repeat (HOLD - 1) step();
        chk("final_hold_flash", 32'(Flash), 32'd1);
        chk("final_hold_win", 32'(Winner), 32'd0);
        step();
        chk("over_win", 32'(Winner), 32'b11);
        chk("over_flash", 32'(Flash), 32'd0);

        // Hits ignored in OVER
        Bullet0X = 10'd300; Bullet0Y = 10'd200;
        Bullet1X = 10'd100; Bullet1Y = 10'd400;
        step();
        step();
        chk("over_hit_s0", 32'(Score0), 32'd9);
        chk("over_hit_s1", 32'(Score1), 32'd9);
        chk("over_hit_gr", 32'(GReset), 32'd0);
        park();

        // Restart, then held key does not retrigger in PLAY/HOLD
        keycode = 8'h28;
        step();
        chk("rs_s0", 32'(Score0), 32'd0);
        chk("rs_s1", 32'(Score1), 32'd0);
        chk("rs_win", 32'(Winner), 32'd0);
        chk("rs_gr", 32'(GReset), 32'd1);
        step();
        chk("rs_gr_off", 32'(GReset), 32'd0);
        chk("rs_flash", 32'(Flash), 32'd0);
        hit_hold(10'd300, 10'd200, 10'd0, 10'd0, 4'd1, 4'd0, "keyheld_hit");
        step();
        chk("keyheld_play_gr", 32'(GReset), 32'd0);
        chk("keyheld_play_s0", 32'(Score0), 32'd1);
        keycode = 8'h00;

        // Async reset mid-HOLD with GReset in flight and Score0=3
        hit_hold(10'd300, 10'd200, 10'd0, 10'd0, 4'd2, 4'd0, "pre_rst");
        Bullet0X = 10'd300; Bullet0Y = 10'd200;
        step();
        chk("pre_rst_s0", 32'(Score0), 32'd3);
        chk("pre_rst_gr", 32'(GReset), 32'd1);
        park();
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_gr", 32'(GReset), 32'd0);
        chk("arst_s0", 32'(Score0), 32'd0);
        chk("arst_flash", 32'(Flash), 32'd0);
        chk("arst_win", 32'(Winner), 32'd0);
        #2 Reset_n = 1'b1;
        step();
        chk("post_rst_flash", 32'(Flash), 32'd0);
        hit_hold(10'd300, 10'd200, 10'd0, 10'd0, 4'd1, 4'd0, "post_rst_hit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
